// File: rtl/verimuldiv_pkg.sv
// verimuldiv_pkg: RV32M multiply/divide opcodes and decode helpers.
package verimuldiv_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {
        MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
        DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7
    } muldiv_fn_t;
    function automatic logic is_div(muldiv_fn_t fn);
        return fn[2];
    endfunction
    function automatic logic is_rem(muldiv_fn_t fn);
        return fn inside {REM, REMU};
    endfunction
    function automatic logic is_signed_a(muldiv_fn_t fn);
        return fn inside {MULH, MULHSU, DIV, REM};
    endfunction
    function automatic logic is_signed_b(muldiv_fn_t fn);
        return fn inside {MULH, DIV, REM};
    endfunction
    function automatic logic is_high(muldiv_fn_t fn);
        return fn inside {MULH, MULHSU, MULHU};
    endfunction
endpackage

// File: rtl/verimuldiv_step.sv
// verimuldiv_step: one radix-2 iteration, shift-add multiply or restoring divide.
module verimuldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    logic [WIDTH:0] sum, shifted, diff;
    assign sum     = {1'b0, hi} + {1'b0, (lo[0] ? d : {WIDTH{1'b0}})};
    // hi stays below d, so the shifted partial remainder fits WIDTH+1 bits
    assign shifted = {hi, lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, d};
    assign hi_n    = div ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    assign lo_n    = div ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
endmodule

// File: rtl/verimuldiv.sv
// verimuldiv: iterative RV32M multiply/divide unit, one bit per cycle, valid/ready in, pulse out.
module verimuldiv
    import verimuldiv_pkg::*;
#(
    parameter int WIDTH = $bits(word_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] r
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    muldiv_fn_t op, fn_in;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, d, hi_n, lo_n, abs_a, abs_b, special_r, quo, rem, result;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic neg_q, neg_r, sa, sb, accept, b_zero, ovf, special, last;
    assign fn_in     = muldiv_fn_t'(fn);
    assign ready_out = state == IDLE;
    assign valid_out = state == DONE;
    assign accept    = valid_in && ready_out;
    assign sa        = is_signed_a(fn_in) && a[WIDTH-1];
    assign sb        = is_signed_b(fn_in) && b[WIDTH-1];
    assign abs_a     = sa ? -a : a;
    assign abs_b     = sb ? -b : b;
    assign b_zero    = b == '0;
    assign ovf       = fn_in inside {DIV, REM} && a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
    assign special   = is_div(fn_in) && (b_zero || ovf);
    assign special_r = b_zero ? (is_rem(fn_in) ? a : '1) : (is_rem(fn_in) ? '0 : a);
    assign last      = cnt == CW'(WIDTH - 1);
    verimuldiv_step #(.WIDTH(WIDTH)) u_step (
        .div(is_div(op)), .hi(hi), .lo(lo), .d(d), .hi_n(hi_n), .lo_n(lo_n)
    );
    // final sign fix-up is taken straight off the last step so DONE lands WIDTH cycles after RUN starts
    assign prod     = {hi_n, lo_n};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo      = neg_q ? -lo_n : lo_n;
    assign rem      = neg_r ? -hi_n : hi_n;
    assign result   = is_div(op) ? (is_rem(op) ? rem : quo)
                                 : (is_high(op) ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0]);
    always_comb begin
        state_n = state;
        if (state == IDLE && accept) state_n = special ? DONE : RUN;
        else if (state == RUN && last) state_n = DONE;
        else if (state == DONE) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op    <= MUL;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            d     <= '0;
            cnt   <= '0;
            r     <= '0;
        end else if (accept) begin
            op    <= fn_in;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            hi    <= '0;
            lo    <= is_div(fn_in) ? abs_a : abs_b;
            d     <= is_div(fn_in) ? abs_b : abs_a;
            cnt   <= '0;
            if (special) r <= special_r;
        end else if (state == RUN) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (last) r <= result;
        end
    end
endmodule
